// File: rtl/cw305_seq_pkg.sv
// Shared encodings and helpers for the CW305 crypto-core batch sequencer.
package cw305_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_FIXED  = 2'd1,
        MODE_CHAIN  = 2'd2,
        MODE_INCR   = 2'd3
    } seq_mode_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RDY = 2'd1,
        S_RUN      = 2'd2,
        S_GAP      = 2'd3
    } seq_state_e;

    // Per-op timeout limit in cycles for a counter of the given width.
    function automatic logic [63:0] timeout_limit(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/cw305_seq_timer.sv
// Loadable down-counter that parks at zero; used for the inter-op gap and the per-op timeout.
module cw305_seq_timer #(
    parameter int pWIDTH = 16
) (
    input  logic              crypto_clk,
    input  logic              reset_i,
    input  logic              load,
    input  logic [pWIDTH-1:0] load_value,
    input  logic              enable,
    output logic              zero
);

    logic [pWIDTH-1:0] count;

    // NOTE: clocked state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !zero) begin
            count <= count - pWIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cw305_crypto_sequencer.sv
// Batch sequencer between the register block and a crypto core: launches N ops per start,
// chains or increments the text, inserts a gap, drives the scope trigger, and aborts on timeout.
module cw305_crypto_sequencer
    import cw305_seq_pkg::*;
#(
    parameter int pPT_WIDTH      = 128,
    parameter int pCT_WIDTH      = 128,
    parameter int pKEY_WIDTH     = 128,
    parameter int pCOUNT_WIDTH   = 16,
    parameter int pDELAY_WIDTH   = 16,
    parameter int pTIMEOUT_WIDTH = 24
) (
    input  logic                    crypto_clk,
    input  logic                    reset_i,
    input  logic                    I_start,
    input  logic                    I_abort,
    input  logic [1:0]              I_mode,
    input  logic [pCOUNT_WIDTH-1:0] I_count,
    input  logic [pDELAY_WIDTH-1:0] I_gap,
    input  logic [pKEY_WIDTH-1:0]   I_key,
    input  logic [pPT_WIDTH-1:0]    I_textin,
    output logic                    O_core_start,
    output logic [pKEY_WIDTH-1:0]   O_core_key,
    output logic [pPT_WIDTH-1:0]    O_core_text,
    input  logic                    I_core_ready,
    input  logic                    I_core_done,
    input  logic                    I_core_busy,
    input  logic [pCT_WIDTH-1:0]    I_core_cipher,
    output logic [pCT_WIDTH-1:0]    O_cipherout,
    output logic [pCOUNT_WIDTH-1:0] O_remaining,
    output logic                    O_busy,
    output logic                    O_done,
    output logic                    O_timeout,
    output logic                    O_trigger
);

    localparam logic [pTIMEOUT_WIDTH-1:0] TMO_RELOAD =
        pTIMEOUT_WIDTH'(timeout_limit(pTIMEOUT_WIDTH) - 64'd1);

    seq_state_e              state, next_state;
    seq_mode_e               mode_q;
    logic [pDELAY_WIDTH-1:0] gap_q;
    logic                    run_first;
    logic                    accept_start, launch, op_complete, batch_end, op_timeout, abort_now;
    logic                    op_active, run_done, gap_zero, tmo_zero, gap_load, tmo_load;
    logic [pCOUNT_WIDTH-1:0] start_count;
    logic [pPT_WIDTH-1:0]    next_text;

    assign op_active = (state == S_WAIT_RDY) || (state == S_RUN);
    // The first RUN cycle is skipped so a done level left over from the previous op is not taken.
    assign run_done  = (state == S_RUN) && !run_first && I_core_done && !I_core_busy;
    assign O_busy    = (state != S_IDLE);

    assign start_count = ((seq_mode_e'(I_mode) == MODE_SINGLE) || (I_count == '0))
                         ? pCOUNT_WIDTH'(1) : I_count;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        next_state   = state;
        accept_start = 1'b0;
        launch       = 1'b0;
        op_complete  = 1'b0;
        batch_end    = 1'b0;
        op_timeout   = 1'b0;
        abort_now    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (I_start) begin
                    accept_start = 1'b1;
                    next_state   = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (I_core_ready) begin
                    launch     = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (run_done) begin
                    op_complete = 1'b1;
                    if (O_remaining == pCOUNT_WIDTH'(1)) begin
                        batch_end  = 1'b1;
                        next_state = S_IDLE;
                    end else if (gap_q != '0) begin
                        next_state = S_GAP;
                    end else begin
                        next_state = S_WAIT_RDY;
                    end
                end
            end
            S_GAP: begin
                if (gap_zero) next_state = S_WAIT_RDY;
            end
            default: next_state = S_IDLE;
        endcase

        if (op_active && tmo_zero && !op_complete) begin
            launch     = 1'b0;
            op_timeout = 1'b1;
            next_state = S_IDLE;
        end

        if ((state != S_IDLE) && I_abort) begin
            launch      = 1'b0;
            op_complete = 1'b0;
            batch_end   = 1'b0;
            op_timeout  = 1'b0;
            abort_now   = 1'b1;
            next_state  = S_IDLE;
        end
    end

    always_comb begin
        next_text = O_core_text;
        unique case (mode_q)
            MODE_CHAIN: next_text = pPT_WIDTH'(I_core_cipher);
            MODE_INCR:  next_text = O_core_text + pPT_WIDTH'(1);
            default:    next_text = O_core_text;
        endcase
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= next_state;
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            mode_q       <= MODE_SINGLE;
            gap_q        <= '0;
            run_first    <= 1'b0;
            O_core_start <= 1'b0;
            O_core_key   <= '0;
            O_core_text  <= '0;
            O_cipherout  <= '0;
            O_remaining  <= '0;
            O_done       <= 1'b0;
            O_timeout    <= 1'b0;
            O_trigger    <= 1'b0;
        end else begin
            O_core_start <= launch;
            O_done       <= batch_end;
            run_first    <= launch;
            if (accept_start) begin
                mode_q      <= seq_mode_e'(I_mode);
                gap_q       <= I_gap;
                O_core_key  <= I_key;
                O_core_text <= I_textin;
                O_remaining <= start_count;
                O_timeout   <= 1'b0;
            end
            if (launch) O_trigger <= 1'b1;
            if (op_complete) begin
                O_cipherout <= I_core_cipher;
                O_trigger   <= 1'b0;
                O_remaining <= O_remaining - pCOUNT_WIDTH'(1);
                if (!batch_end) O_core_text <= next_text;
            end
            if (op_timeout) begin
                O_timeout <= 1'b1;
                O_trigger <= 1'b0;
            end
            if (abort_now) begin
                O_trigger   <= 1'b0;
                O_remaining <= '0;
            end
        end
    end

    assign gap_load = (next_state == S_GAP) && (state != S_GAP);
    assign tmo_load = (next_state == S_WAIT_RDY) && (state != S_WAIT_RDY);

    cw305_seq_timer #(.pWIDTH(pDELAY_WIDTH)) u_gap_timer (
        .crypto_clk (crypto_clk),
        .reset_i    (reset_i),
        .load       (gap_load),
        .load_value (gap_q - pDELAY_WIDTH'(1)),
        .enable     (state == S_GAP),
        .zero       (gap_zero)
    );

    cw305_seq_timer #(.pWIDTH(pTIMEOUT_WIDTH)) u_timeout_timer (
        .crypto_clk (crypto_clk),
        .reset_i    (reset_i),
        .load       (tmo_load),
        .load_value (TMO_RELOAD),
        .enable     (op_active),
        .zero       (tmo_zero)
    );

endmodule
